// File: rtl/dfr_pkg.sv
// Shared fetch-state encoding, default sample counts and counter sizing helper
// for the DFR sample sequencer.
package dfr_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_DRIVE = 2'd2
  } fetch_state_e;

  localparam int DFR_NUM_INIT_SAMPLES = 16;
  localparam int DFR_NUM_SAMPLES      = 64;
  localparam int DFR_NUM_FILL_SAMPLES = 8;

  // Bits needed to hold every value 0..limit inclusive.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dfr_sample_sequencer_if.sv
// Sample-memory read bus between the sequencer (master) and the sample store (slave).
interface dfr_sample_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  mem_rd_req;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_rd_ack;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    output mem_rd_req,
    output mem_rd_addr,
    input  mem_rd_ack,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_req,
    input  mem_rd_addr,
    output mem_rd_ack,
    output mem_rd_data
  );

endinterface

// File: rtl/dfr_sat_counter.sv
// Up-counter that stops at LIMIT; a clear on the same cycle as an enable wins.
module dfr_sat_counter
  import dfr_pkg::*;
#(
  parameter int LIMIT = DFR_NUM_SAMPLES,
  parameter int W     = cnt_width(LIMIT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_limit
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !at_limit) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign at_limit = (count_q == W'(LIMIT));

endmodule

// File: rtl/dfr_sample_sequencer.sv
// Washout/main-phase sample sequencer: tracks sample counts and fetches one sample
// per reservoir_en from memory. Optional ack timeout enabled by DFR_SEQ_TIMEOUT_EN.
module dfr_sample_sequencer
  import dfr_pkg::*;
#(
  parameter int                    ADDR_WIDTH       = 32,
  parameter int                    DATA_WIDTH       = 32,
  parameter int                    NUM_INIT_SAMPLES = DFR_NUM_INIT_SAMPLES,
  parameter int                    NUM_SAMPLES      = DFR_NUM_SAMPLES,
  parameter int                    NUM_FILL_SAMPLES = DFR_NUM_FILL_SAMPLES,
  parameter logic [ADDR_WIDTH-1:0] INIT_BASE        = '0,
  parameter logic [ADDR_WIDTH-1:0] SAMPLE_BASE      = 'h100,
  parameter int                    TIMEOUT_CYCLES   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_sample_cntr_rst,
  input  logic                   sample_cntr_rst,
  input  logic                   sample_cntr_en,
  input  logic                   reservoir_en,
  dfr_sample_sequencer_if.master mem,
  output logic [DATA_WIDTH-1:0]  reservoir_din,
  output logic                   reservoir_din_valid,
  output logic                   reservoir_init_busy,
  output logic                   reservoir_busy,
  output logic                   reservoir_filled,
  output logic [ADDR_WIDTH-1:0]  history_addr,
  output logic                   overrun_err,
  output logic                   timeout_err
);

  localparam int INIT_W = cnt_width(NUM_INIT_SAMPLES);
  localparam int MAIN_W = cnt_width(NUM_SAMPLES);

  logic [INIT_W-1:0] init_cnt;
  logic [MAIN_W-1:0] main_cnt;
  logic              init_at_limit, main_at_limit;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  overrun_q, overrun_d;
  logic                  tmo_hit;

  // Strobes go to the washout counter until it saturates, then to the main counter.
  dfr_sat_counter #(.LIMIT(NUM_INIT_SAMPLES), .W(INIT_W)) u_init_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (init_sample_cntr_rst),
    .en       (sample_cntr_en && reservoir_init_busy),
    .count    (init_cnt),
    .at_limit (init_at_limit)
  );

  dfr_sat_counter #(.LIMIT(NUM_SAMPLES), .W(MAIN_W)) u_main_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (init_sample_cntr_rst || sample_cntr_rst),
    .en       (sample_cntr_en && !reservoir_init_busy),
    .count    (main_cnt),
    .at_limit (main_at_limit)
  );

  assign reservoir_init_busy = !init_at_limit;
  assign reservoir_busy      = !main_at_limit;
  assign reservoir_filled    = (ADDR_WIDTH'(main_cnt) >= ADDR_WIDTH'(NUM_FILL_SAMPLES));
  assign history_addr        = reservoir_filled
                               ? ADDR_WIDTH'(main_cnt) - ADDR_WIDTH'(NUM_FILL_SAMPLES)
                               : '0;

`ifdef DFR_SEQ_TIMEOUT_EN
  localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;

  // The wait counter restarts on every fetch because it is held at zero outside REQ.
  assign tmo_hit = (state_q == FETCH_REQ) && !mem.mem_rd_ack &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = '0;
    timeout_d = timeout_q;
    if (init_sample_cntr_rst) begin
      timeout_d = 1'b0;
    end else if (state_q == FETCH_REQ) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      if (tmo_hit) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (init_sample_cntr_rst) begin
      state_d = FETCH_IDLE;
    end else begin
      case (state_q)
        FETCH_IDLE:  if (reservoir_en) state_d = FETCH_REQ;
        FETCH_REQ:   if (mem.mem_rd_ack || tmo_hit) state_d = FETCH_DRIVE;
        FETCH_DRIVE: state_d = FETCH_IDLE;
        default:     state_d = FETCH_IDLE;
      endcase
    end
  end

  // Request and valid decode straight from the state so an async reset drops them at once.
  always_comb begin
    mem.mem_rd_req      = (state_q == FETCH_REQ);
    reservoir_din_valid = (state_q == FETCH_DRIVE);
  end

  always_comb begin
    addr_d    = addr_q;
    din_d     = din_q;
    overrun_d = overrun_q;
    if (init_sample_cntr_rst) begin
      overrun_d = 1'b0;
    end else begin
      if (state_q == FETCH_IDLE && reservoir_en) begin
        addr_d = reservoir_init_busy ? INIT_BASE + ADDR_WIDTH'(init_cnt)
                                     : SAMPLE_BASE + ADDR_WIDTH'(main_cnt);
      end
      if (state_q != FETCH_IDLE && reservoir_en) begin
        overrun_d = 1'b1;
      end
      if (state_q == FETCH_REQ) begin
        if (mem.mem_rd_ack) begin
          din_d = mem.mem_rd_data;
        end else if (tmo_hit) begin
          din_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      din_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      din_q     <= din_d;
      overrun_q <= overrun_d;
    end
  end

  assign mem.mem_rd_addr = addr_q;
  assign reservoir_din   = din_q;
  assign overrun_err     = overrun_q;

endmodule

// File: tb/tb_dfr_sample_sequencer.sv
// Table-driven bench for dfr_sample_sequencer with a fetch scoreboard; covers the
// timeout path when DFR_SEQ_TIMEOUT_EN is defined.
module tb_dfr_sample_sequencer;

  localparam int              AW          = 32;
  localparam int              DW          = 32;
  localparam int              NI          = 4;
  localparam int              NS          = 8;
  localparam int              FILL        = 3;
  localparam logic [AW-1:0]   INIT_BASE   = '0;
  localparam logic [AW-1:0]   SAMPLE_BASE = 'h100;
  localparam int              TMO         = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_sample_cntr_rst, sample_cntr_rst, sample_cntr_en, reservoir_en;
  logic [DW-1:0] reservoir_din;
  logic          reservoir_din_valid;
  logic          reservoir_init_busy, reservoir_busy, reservoir_filled;
  logic [AW-1:0] history_addr;
  logic          overrun_err, timeout_err;

  dfr_sample_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  dfr_sample_sequencer #(
    .ADDR_WIDTH       (AW),
    .DATA_WIDTH       (DW),
    .NUM_INIT_SAMPLES (NI),
    .NUM_SAMPLES      (NS),
    .NUM_FILL_SAMPLES (FILL),
    .INIT_BASE        (INIT_BASE),
    .SAMPLE_BASE      (SAMPLE_BASE),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .init_sample_cntr_rst (init_sample_cntr_rst),
    .sample_cntr_rst      (sample_cntr_rst),
    .sample_cntr_en       (sample_cntr_en),
    .reservoir_en         (reservoir_en),
    .mem                  (mem_if),
    .reservoir_din        (reservoir_din),
    .reservoir_din_valid  (reservoir_din_valid),
    .reservoir_init_busy  (reservoir_init_busy),
    .reservoir_busy       (reservoir_busy),
    .reservoir_filled     (reservoir_filled),
    .history_addr         (history_addr),
    .overrun_err          (overrun_err),
    .timeout_err          (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          initRst;
    logic          smpRst;
    logic          en;
    logic          fetch;
    logic [AW-1:0] fetchAddr;
    logic          expInitBusy;
    logic          expBusy;
    logic          expFilled;
    logic [AW-1:0] expHist;
  } vec_t;

  vec_t          vecs[$];
  logic [AW-1:0] addrQ[$];
  logic [DW-1:0] dinQ[$];
  int            nVec = 0;
  int            nErr = 0;
  int            initM = 0;
  int            mainM = 0;
  logic          reqPrev = 1'b0;
  logic          validPrev = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] expAddr();
    return (initM < NI) ? INIT_BASE + AW'(initM) : SAMPLE_BASE + AW'(mainM);
  endfunction

  // Reference counter model advanced as each table row is built.
  task automatic addVec(input logic ir, input logic sr, input logic en, input logic fetch);
    vec_t v;
    v.initRst   = ir;
    v.smpRst    = sr;
    v.en        = en;
    v.fetch     = fetch;
    v.fetchAddr = expAddr();
    if (ir) begin
      initM = 0;
      mainM = 0;
    end else begin
      if (en && initM < NI) initM++;
      else if (en && !sr && mainM < NS) mainM++;
      if (sr) mainM = 0;
    end
    v.expInitBusy = (initM < NI);
    v.expBusy     = (mainM < NS);
    v.expFilled   = (mainM >= FILL);
    v.expHist     = (mainM >= FILL) ? AW'(mainM - FILL) : '0;
    vecs.push_back(v);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_init_busy"}, 32'(reservoir_init_busy), 1);
    checkOutput({tag, "_busy"}, 32'(reservoir_busy), 1);
    checkOutput({tag, "_filled"}, 32'(reservoir_filled), 0);
    checkOutput({tag, "_hist"}, history_addr, 0);
    checkOutput({tag, "_req"}, 32'(mem_if.mem_rd_req), 0);
    checkOutput({tag, "_addr"}, mem_if.mem_rd_addr, 0);
    checkOutput({tag, "_din"}, reservoir_din, 0);
    checkOutput({tag, "_valid"}, 32'(reservoir_din_valid), 0);
    checkOutput({tag, "_overrun"}, 32'(overrun_err), 0);
    checkOutput({tag, "_timeout"}, 32'(timeout_err), 0);
  endtask

  // One complete fetch: req must stay high for ackDelay cycles, ack lands on the last one.
  task automatic doFetch(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int ackDelay);
    addrQ.push_back(addr);
    dinQ.push_back(data);
    @(posedge clk); #1 reservoir_en = 1'b1;
    @(posedge clk); #1 reservoir_en = 1'b0;
    for (int i = 1; i <= ackDelay; i++) begin
      checkOutput($sformatf("fetch_req_c%0d", i), 32'(mem_if.mem_rd_req), 1);
      if (i == ackDelay) begin
        mem_if.mem_rd_ack  = 1'b1;
        mem_if.mem_rd_data = data;
      end
      @(posedge clk); #1 mem_if.mem_rd_ack = 1'b0;
    end
    checkOutput("fetch_req_after_ack", 32'(mem_if.mem_rd_req), 0);
    checkOutput("fetch_valid_after_ack", 32'(reservoir_din_valid), 1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    if (v.fetch) doFetch(v.fetchAddr, DW'($urandom), 1 + (idx % 4));
    @(posedge clk); #1;
    init_sample_cntr_rst = v.initRst;
    sample_cntr_rst      = v.smpRst;
    sample_cntr_en       = v.en;
    @(posedge clk); #1;
    init_sample_cntr_rst = 1'b0;
    sample_cntr_rst      = 1'b0;
    sample_cntr_en       = 1'b0;
    checkOutput($sformatf("v%0d_init_busy", idx), 32'(reservoir_init_busy), 32'(v.expInitBusy));
    checkOutput($sformatf("v%0d_busy", idx), 32'(reservoir_busy), 32'(v.expBusy));
    checkOutput($sformatf("v%0d_filled", idx), 32'(reservoir_filled), 32'(v.expFilled));
    checkOutput($sformatf("v%0d_hist", idx), history_addr, v.expHist);
  endtask

  // Scoreboard: addresses popped when req rises, data popped on each valid pulse.
  always @(negedge clk) begin
    if (mem_if.mem_rd_req && !reqPrev) begin
      if (addrQ.size() == 0) checkOutput("unexpected_req", 32'(mem_if.mem_rd_req), 0);
      else checkOutput("fetch_addr", mem_if.mem_rd_addr, addrQ.pop_front());
    end
    if (reservoir_din_valid) begin
      checkOutput("valid_single_cycle", 32'(validPrev), 0);
      if (dinQ.size() == 0) checkOutput("unexpected_valid", 32'(reservoir_din_valid), 0);
      else checkOutput("fetch_din", reservoir_din, dinQ.pop_front());
    end
    reqPrev   = mem_if.mem_rd_req;
    validPrev = reservoir_din_valid;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            reqCycles;

    addVec(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NI; i++) addVec(1'b0, 1'b0, 1'b1, 1'b1);
    addVec(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NS + 1; i++) addVec(1'b0, 1'b0, 1'b1, 1'b1);
    addVec(1'b0, 1'b1, 1'b1, 1'b0);
    addVec(1'b0, 1'b0, 1'b1, 1'b1);

    rst                  = 1'b1;
    init_sample_cntr_rst = 1'b0;
    sample_cntr_rst      = 1'b0;
    sample_cntr_en       = 1'b0;
    reservoir_en         = 1'b0;
    mem_if.mem_rd_ack    = 1'b0;
    mem_if.mem_rd_data   = '0;
    repeat (2) @(posedge clk);
    #1 checkResetState("reset");
    rst = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    doFetch(expAddr(), 'hA5, 5);
    @(posedge clk); #1 checkOutput("lat_valid_dropped", 32'(reservoir_din_valid), 0);
    checkOutput("lat_din_held", reservoir_din, 'hA5);

    // Second reservoir_en while a fetch is pending.
    a = expAddr();
    d = 'h3C3C_0F0F;
    addrQ.push_back(a);
    dinQ.push_back(d);
    @(posedge clk); #1 reservoir_en = 1'b1;
    @(posedge clk); #1 checkOutput("ovr_req_c1", 32'(mem_if.mem_rd_req), 1);
    @(posedge clk); #1 reservoir_en = 1'b0;
    checkOutput("ovr_err_set", 32'(overrun_err), 1);
    checkOutput("ovr_req_c2", 32'(mem_if.mem_rd_req), 1);
    checkOutput("ovr_addr_stable", mem_if.mem_rd_addr, a);
    mem_if.mem_rd_ack  = 1'b1;
    mem_if.mem_rd_data = d;
    @(posedge clk); #1 mem_if.mem_rd_ack = 1'b0;
    checkOutput("ovr_valid", 32'(reservoir_din_valid), 1);
    checkOutput("ovr_din", reservoir_din, d);
    @(posedge clk); #1;
    mem_if.mem_rd_ack  = 1'b1;
    mem_if.mem_rd_data = 'hDEAD_BEEF;
    @(posedge clk); #1 mem_if.mem_rd_ack = 1'b0;
    checkOutput("idle_ack_no_valid", 32'(reservoir_din_valid), 0);
    checkOutput("idle_ack_din_kept", reservoir_din, d);
    checkOutput("ovr_sticky", 32'(overrun_err), 1);
    @(posedge clk); #1 init_sample_cntr_rst = 1'b1;
    @(posedge clk); #1 init_sample_cntr_rst = 1'b0;
    initM = 0;
    mainM = 0;
    checkOutput("ovr_cleared", 32'(overrun_err), 0);
    checkOutput("ovr_init_busy_again", 32'(reservoir_init_busy), 1);

    // Asynchronous reset while waiting for an ack.
    addrQ.push_back(expAddr());
    @(posedge clk); #1 reservoir_en = 1'b1;
    @(posedge clk); #1 reservoir_en = 1'b0;
    checkOutput("rst_req_before", 32'(mem_if.mem_rd_req), 1);
    @(posedge clk); #3 rst = 1'b1;
    #1 checkOutput("rst_req_async", 32'(mem_if.mem_rd_req), 0);
    checkOutput("rst_no_valid", 32'(reservoir_din_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkResetState("midrst");
    initM = 0;
    mainM = 0;
    @(posedge clk); #1 checkOutput("midrst_still_no_valid", 32'(reservoir_din_valid), 0);

`ifdef DFR_SEQ_TIMEOUT_EN
    addrQ.push_back(expAddr());
    dinQ.push_back('0);
    @(posedge clk); #1 reservoir_en = 1'b1;
    @(posedge clk); #1 reservoir_en = 1'b0;
    reqCycles = 0;
    for (int i = 0; i < TMO + 5; i++) begin
      if (!mem_if.mem_rd_req) break;
      reqCycles++;
      @(posedge clk); #1;
    end
    checkOutput("tmo_req_cycles", reqCycles, TMO);
    checkOutput("tmo_valid", 32'(reservoir_din_valid), 1);
    checkOutput("tmo_din_zero", reservoir_din, 0);
    checkOutput("tmo_err_set", 32'(timeout_err), 1);
    @(posedge clk); #1 checkOutput("tmo_err_sticky", 32'(timeout_err), 1);
`else
    addrQ.push_back(expAddr());
    dinQ.push_back('h5A);
    @(posedge clk); #1 reservoir_en = 1'b1;
    @(posedge clk); #1 reservoir_en = 1'b0;
    reqCycles = 0;
    for (int i = 0; i < 2 * TMO; i++) begin
      if (!mem_if.mem_rd_req) break;
      reqCycles++;
      @(posedge clk); #1;
    end
    checkOutput("notmo_req_held", reqCycles, 2 * TMO);
    checkOutput("notmo_err_zero", 32'(timeout_err), 0);
    mem_if.mem_rd_ack  = 1'b1;
    mem_if.mem_rd_data = 'h5A;
    @(posedge clk); #1 mem_if.mem_rd_ack = 1'b0;
    checkOutput("notmo_valid", 32'(reservoir_din_valid), 1);
`endif

    repeat (2) @(posedge clk);
    #1 checkOutput("addr_queue_drained", addrQ.size(), 0);
    checkOutput("din_queue_drained", dinQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
